// File: rtl/seg_pkg.sv
// Shared types and constants for the 2-digit 7-segment scan driver.
// Segment codes are active-low with the decimal point off (bit7=1).
package seg_pkg;

   // Scan phases in frame order
   typedef enum logic [1:0] {
      GAP_T = 2'd0,
      UNIT  = 2'd1,
      GAP_U = 2'd2,
      TEN   = 2'd3
   } state_t;

   localparam logic [7:0] SEG_0     = 8'hC0;
   localparam logic [7:0] SEG_1     = 8'hF9;
   localparam logic [7:0] SEG_2     = 8'hA4;
   localparam logic [7:0] SEG_3     = 8'hB0;
   localparam logic [7:0] SEG_4     = 8'h99;
   localparam logic [7:0] SEG_5     = 8'h92;
   localparam logic [7:0] SEG_6     = 8'h82;
   localparam logic [7:0] SEG_7     = 8'hF8;
   localparam logic [7:0] SEG_8     = 8'h80;
   localparam logic [7:0] SEG_9     = 8'h90;
   localparam logic [7:0] SEG_DASH  = 8'hBF;
   localparam logic [7:0] SEG_BLANK = 8'hFF;

   // Digit enables, active-low: bit0 = units, bit1 = tens
   localparam logic [1:0] SEL_OFF  = 2'b11;
   localparam logic [1:0] SEL_UNIT = 2'b10;
   localparam logic [1:0] SEL_TEN  = 2'b01;

   // Larger of two integers, used to size the shared phase counter
   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// Digit input / display output bundle of the scan driver.
// master: the digit source (drives ten/unit/load, observes the display).
// slave : the scan driver itself.
interface seg_scan_driver_if;
   logic [3:0] ten;
   logic [3:0] unit;
   logic       load;
   logic [1:0] sel;
   logic [7:0] seg;

   modport master (output ten, output unit, output load, input sel, input seg);
   modport slave  (input ten, input unit, input load, output sel, output seg);
endinterface

// File: rtl/bcd7seg.sv
// Combinational BCD to active-low 7-segment decoder (dp off).
// Non-decimal inputs 10..15 render as a dash.
module bcd7seg
   import seg_pkg::*;
(
   input  logic [3:0] digit,
   output logic [7:0] seg
);

   // Digit to segment lookup
   always_comb begin
      seg = SEG_DASH;
      case (digit)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed driver for a 2-digit common-anode 7-segment display.
// Frame: GAP_T -> UNIT -> GAP_U -> TEN, each gap all-off to suppress ghosting.
// Digits are double-buffered: load writes the pending pair, which is copied
// to the display pair only on entry to GAP_T, so a frame never shows a torn
// value. sel/seg are registered and trail the FSM state by one clock.
// Optional macro SEG_LZB_EN: blank the tens digit when it is zero.
module seg_scan_driver
   import seg_pkg::*;
#(
   parameter int SCAN_DIV = 50000,  // cycles each digit is lit, >= 2
   parameter int GAP_CYC  = 500     // all-off cycles between phases, >= 1
)(
   input  logic               clk,
   input  logic               rst,
   seg_scan_driver_if.slave   bus
);

   localparam int CNT_W = $clog2(max_int(SCAN_DIV, GAP_CYC));
   localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             phase_end;
   logic [3:0]       pend_ten;
   logic [3:0]       pend_unit;
   logic [3:0]       disp_ten;
   logic [3:0]       disp_unit;
   logic [3:0]       digit;
   logic [7:0]       dec_seg;
   logic [1:0]       sel_nxt;
   logic [7:0]       seg_nxt;
   logic [1:0]       sel_q;
   logic [7:0]       seg_q;

   // Last cycle of the current phase: lit phases run SCAN_DIV, gaps GAP_CYC
   always_comb begin
      phase_end = 1'b0;
      if (state == UNIT || state == TEN)
         phase_end = (cnt == SCAN_LAST);
      else
         phase_end = (cnt == GAP_LAST);
   end

   // Only one digit is ever decoded: the one about to be lit
   always_comb begin
      digit = (state == TEN) ? disp_ten : disp_unit;
   end

   bcd7seg u_dec (
      .digit (digit),
      .seg   (dec_seg)
   );

   // Next display drive from the current phase
   always_comb begin
      sel_nxt = SEL_OFF;
      seg_nxt = SEG_BLANK;
      case (state)
         UNIT: begin
            sel_nxt = SEL_UNIT;
            seg_nxt = dec_seg;
         end
         TEN: begin
            sel_nxt = SEL_TEN;
`ifdef SEG_LZB_EN
            // Enable still pulses so the scan timing does not change
            seg_nxt = (disp_ten == 4'd0) ? SEG_BLANK : dec_seg;
`else
            seg_nxt = dec_seg;
`endif
         end
         default: begin
            sel_nxt = SEL_OFF;
            seg_nxt = SEG_BLANK;
         end
      endcase
   end

   // Scan FSM, phase counter and registered display outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= GAP_T;
         cnt   <= '0;
         sel_q <= SEL_OFF;
         seg_q <= SEG_BLANK;
      end else begin
         sel_q <= sel_nxt;
         seg_q <= seg_nxt;
         if (phase_end) begin
            cnt <= '0;
            case (state)
               GAP_T:   state <= UNIT;
               UNIT:    state <= GAP_U;
               GAP_U:   state <= TEN;
               TEN:     state <= GAP_T;
               default: state <= GAP_T;
            endcase
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

   // Double buffer: a load on the GAP_T entry edge lands in pending only,
   // because the display copy sees the pending value from before that edge
   always_ff @(posedge clk) begin
      if (rst) begin
         pend_ten  <= 4'd0;
         pend_unit <= 4'd0;
         disp_ten  <= 4'd0;
         disp_unit <= 4'd0;
      end else begin
         if (bus.load) begin
            pend_ten  <= bus.ten;
            pend_unit <= bus.unit;
         end
         if (state == TEN && phase_end) begin
            disp_ten  <= pend_ten;
            disp_unit <= pend_unit;
         end
      end
   end

   assign bus.sel = sel_q;
   assign bus.seg = seg_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver with SCAN_DIV=4, GAP_CYC=2 (12-cycle frame).
// A frame-position model predicts sel/seg for every clock; predictions are
// queued at the clock edge and compared half a cycle later. A vector table
// plus hand-written sequences cover loads, buffering corners and reset.
module tb_seg_scan_driver;

   localparam int SD    = 4;
   localparam int GC    = 2;
   localparam int FRAME = 2 * (SD + GC);

   typedef struct {
      logic [3:0] ten;
      logic [3:0] unit;
      logic [7:0] exp_u;
      logic [7:0] exp_t;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   seg_scan_driver_if bus ();

   seg_scan_driver #(.SCAN_DIV(SD), .GAP_CYC(GC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   // Reference model state
   int         m_pos = 0;
   logic [3:0] m_pend_t = 4'd0;
   logic [3:0] m_pend_u = 4'd0;
   logic [3:0] m_disp_t = 4'd0;
   logic [3:0] m_disp_u = 4'd0;
   logic [9:0] exp_q[$];

   function automatic logic [7:0] code(input logic [3:0] d);
      case (d)
         4'd0: return 8'hC0;
         4'd1: return 8'hF9;
         4'd2: return 8'hA4;
         4'd3: return 8'hB0;
         4'd4: return 8'h99;
         4'd5: return 8'h92;
         4'd6: return 8'h82;
         4'd7: return 8'hF8;
         4'd8: return 8'h80;
         4'd9: return 8'h90;
         default: return 8'hBF;
      endcase
   endfunction

   function automatic logic [9:0] exp_out(input int pos, input logic [3:0] dt, input logic [3:0] du);
      if (pos < GC)            return {2'b11, 8'hFF};
      if (pos < GC + SD)       return {2'b10, code(du)};
      if (pos < 2 * GC + SD)   return {2'b11, 8'hFF};
`ifdef SEG_LZB_EN
      if (dt == 4'd0)          return {2'b01, 8'hFF};
`endif
      return {2'b01, code(dt)};
   endfunction

   // One clock: predict at the edge, compare at the following falling edge
   task automatic step();
      logic [9:0] e;
      @(posedge clk);
      cyc++;
      if (rst) begin
         m_pos    = 0;
         m_pend_t = 4'd0;
         m_pend_u = 4'd0;
         m_disp_t = 4'd0;
         m_disp_u = 4'd0;
         exp_q.push_back({2'b11, 8'hFF});
      end else begin
         exp_q.push_back(exp_out(m_pos, m_disp_t, m_disp_u));
         if (m_pos == FRAME - 1) begin
            m_disp_t = m_pend_t;
            m_disp_u = m_pend_u;
         end
         if (bus.load) begin
            m_pend_t = bus.ten;
            m_pend_u = bus.unit;
         end
         m_pos = (m_pos + 1) % FRAME;
      end
      @(negedge clk);
      n_tests++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL sb_empty cyc=%0d no prediction queued", cyc);
      end else begin
         e = exp_q.pop_front();
         if ({bus.sel, bus.seg} !== e) begin
            n_fail++;
            $display("FAIL sb cyc=%0d sel/seg got %b/%h want %b/%h",
                     cyc, bus.sel, bus.seg, e[9:8], e[7:0]);
         end
      end
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got %0h want %0h", name, cyc, got, want);
      end
   endtask

   // Step until sel matches; n = steps taken, -1 on timeout
   task automatic wait_sel(input string name, input logic [1:0] s, output int n);
      n = -1;
      for (int k = 1; k <= 40; k++) begin
         step();
         if (bus.sel == s) begin
            n = k;
            break;
         end
      end
      n_tests++;
      if (n < 0) begin
         n_fail++;
         $display("FAIL %s_wait cyc=%0d sel got %b want %b within 40 cycles", name, cyc, bus.sel, s);
      end
   endtask

   task automatic do_load(input logic [3:0] t, input logic [3:0] u);
      bus.ten  = t;
      bus.unit = u;
      bus.load = 1'b1;
      step();
      bus.load = 1'b0;
   endtask

   vec_t       vecs[7];
   logic [7:0] ten0_seg;
   int         n;

   initial begin
`ifdef SEG_LZB_EN
      ten0_seg = 8'hFF;
`else
      ten0_seg = 8'hC0;
`endif
      vecs[0] = '{ten: 4'd0, unit: 4'd7, exp_u: 8'hF8, exp_t: ten0_seg};
      vecs[1] = '{ten: 4'hF, unit: 4'hC, exp_u: 8'hBF, exp_t: 8'hBF};
      vecs[2] = '{ten: 4'd9, unit: 4'd0, exp_u: 8'hC0, exp_t: 8'h90};
      vecs[3] = '{ten: 4'd2, unit: 4'd8, exp_u: 8'h80, exp_t: 8'hA4};
      vecs[4] = '{ten: 4'd6, unit: 4'd3, exp_u: 8'hB0, exp_t: 8'h82};
      vecs[5] = '{ten: 4'd1, unit: 4'd4, exp_u: 8'h99, exp_t: 8'hF9};
      vecs[6] = '{ten: 4'd5, unit: 4'd9, exp_u: 8'h90, exp_t: 8'h92};

      bus.ten  = 4'd0;
      bus.unit = 4'd0;
      bus.load = 1'b0;
      rst      = 1'b1;

      // Reset held 3 cycles, then first units phase after GAP_CYC+1
      repeat (3) step();
      chk("rst_sel", 32'(bus.sel), 32'h3);
      chk("rst_seg", 32'(bus.seg), 32'hFF);
      rst = 1'b0;
      wait_sel("first_unit", 2'b10, n);
      chk("first_unit_lat", n, 3);
      chk("first_unit_seg", 32'(bus.seg), 32'hC0);

      // Vector table: load, let the frame roll over, read both digits
      for (int i = 0; i < 7; i++) begin
         do_load(vecs[i].ten, vecs[i].unit);
         repeat (2 * FRAME) step();
         wait_sel("vec_u", 2'b10, n);
         chk($sformatf("vec%0d_unit_seg", i), 32'(bus.seg), 32'(vecs[i].exp_u));
         wait_sel("vec_t", 2'b01, n);
         chk($sformatf("vec%0d_ten_seg", i), 32'(bus.seg), 32'(vecs[i].exp_t));
      end

      // Load mid-UNIT: current frame keeps 5/9, next frame shows 3/1
      wait_sel("mid_u", 2'b10, n);
      step();
      do_load(4'd3, 4'd1);
      wait_sel("mid_t_old", 2'b01, n);
      chk("midload_old_ten", 32'(bus.seg), 32'h92);
      wait_sel("mid_u_new", 2'b10, n);
      chk("midload_new_unit", 32'(bus.seg), 32'hF9);
      wait_sel("mid_t_new", 2'b01, n);
      chk("midload_new_ten", 32'(bus.seg), 32'hB0);

      // Back-to-back loads: the last one wins
      do_load(4'd1, 4'd2);
      do_load(4'd4, 4'd6);
      repeat (2 * FRAME) step();
      wait_sel("b2b_u", 2'b10, n);
      chk("b2b_unit", 32'(bus.seg), 32'h82);
      wait_sel("b2b_t", 2'b01, n);
      chk("b2b_ten", 32'(bus.seg), 32'h99);

      // Load on the GAP_T entry edge: shown one frame later
      n = 0;
      while (m_pos != FRAME - 1 && n < 40) begin
         step();
         n++;
      end
      chk("edge_align", m_pos, FRAME - 1);
      do_load(4'd8, 4'd0);
      wait_sel("edge_u_old", 2'b10, n);
      chk("edgeload_old_unit", 32'(bus.seg), 32'h82);
      wait_sel("edge_t_old", 2'b01, n);
      chk("edgeload_old_ten", 32'(bus.seg), 32'h99);
      wait_sel("edge_u_new", 2'b10, n);
      chk("edgeload_new_unit", 32'(bus.seg), 32'hC0);
      wait_sel("edge_t_new", 2'b01, n);
      chk("edgeload_new_ten", 32'(bus.seg), 32'h80);

      // One-cycle reset during TEN: blank at once, restart, pending lost
      do_load(4'd7, 4'd7);
      wait_sel("rst_t", 2'b01, n);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("midrst_sel", 32'(bus.sel), 32'h3);
      chk("midrst_seg", 32'(bus.seg), 32'hFF);
      wait_sel("rst_first_u", 2'b10, n);
      chk("midrst_unit_lat", n, 3);
      chk("midrst_unit_seg", 32'(bus.seg), 32'hC0);
      wait_sel("rst_t2", 2'b01, n);
      chk("midrst_ten_seg", 32'(bus.seg), 32'(ten0_seg));
      wait_sel("rst_u3", 2'b10, n);
      chk("pend_lost_unit", 32'(bus.seg), 32'hC0);
      wait_sel("rst_t3", 2'b01, n);
      chk("pend_lost_ten", 32'(bus.seg), 32'(ten0_seg));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog cyc=%0d simulation did not finish", cyc);
      $fatal(1, "watchdog");
   end

endmodule
